// File: rtl/uec_dbg_pkg.sv
// Shared debug-block definitions: dump FSM state encoding and register-file geometry.
package uec_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CAPT = 3'd1,
        ST_HDR  = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } dump_state_e;

    localparam int         NUM_REGS = 16;
    localparam int         SEL_W    = $clog2(NUM_REGS);
    localparam logic [3:0] LAST_REG = 4'hF;

endpackage

// File: rtl/regfile_dump.sv
// Register-file dump engine: walks monitor_sel 0..15 and streams each value MSB byte first.
// Define REGDUMP_HDR_EN to prefix every register with its index byte.
import uec_dbg_pkg::*;

module regfile_dump #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       monitor_sel,
    input  logic [WIDTH-1:0] monitor_data,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    // state | meaning
    // IDLE  | waiting for start
    // CAPT  | snapshot monitor_data of register sel
    // HDR   | sending index byte (REGDUMP_HDR_EN only)
    // SEND  | sending shadow bytes, byte_cnt counts down to 0
    // DONE  | one-cycle completion pulse

    localparam int NBYTES = WIDTH / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

    dump_state_e      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [7:0]       send_byte;
    logic             hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            byte_cnt_q <= '0;
            shadow_q   <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            byte_cnt_q <= byte_cnt_d;
            shadow_q   <= shadow_d;
        end
    end

    always_comb begin
        send_byte = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if (byte_cnt_q == CNT_W'(b)) begin
                send_byte = shadow_q[8*b +: 8];
            end
        end
    end

    // Outputs decode only registered state, so tx_ready/start never reach an output.
    always_comb begin
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        monitor_sel = sel_q;
`ifdef REGDUMP_HDR_EN
        tx_valid    = (state_q == ST_SEND) || (state_q == ST_HDR);
        if (state_q == ST_HDR) begin
            tx_data = {4'h0, sel_q};
        end else if (state_q == ST_SEND) begin
            tx_data = send_byte;
        end else begin
            tx_data = 8'h00;
        end
`else
        tx_valid    = (state_q == ST_SEND);
        tx_data     = (state_q == ST_SEND) ? send_byte : 8'h00;
`endif
    end

    assign hs = tx_valid && tx_ready;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        byte_cnt_d = byte_cnt_q;
        shadow_d   = shadow_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d   = '0;
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                shadow_d   = monitor_data;
                byte_cnt_d = CNT_LAST;
`ifdef REGDUMP_HDR_EN
                state_d    = ST_HDR;
`else
                state_d    = ST_SEND;
`endif
            end
`ifdef REGDUMP_HDR_EN
            ST_HDR: begin
                if (hs) begin
                    state_d = ST_SEND;
                end
            end
`endif
            ST_SEND: begin
                if (hs) begin
                    if (byte_cnt_q != '0) begin
                        byte_cnt_d = byte_cnt_q - CNT_W'(1);
                    end else if (sel_q == LAST_REG) begin
                        state_d = ST_DONE;
                    end else begin
                        sel_d   = sel_q + SEL_W'(1);
                        state_d = ST_CAPT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: stream model built from a register snapshot plus directed cases.
// Honours REGDUMP_HDR_EN the same way as the design.
module tb_regfile_dump;

    localparam int WIDTH = 16;
    localparam int NB    = WIDTH / 8;
`ifdef REGDUMP_HDR_EN
    localparam int HOFF  = 1;
`else
    localparam int HOFF  = 0;
`endif
    localparam int BPR       = NB + HOFF;
    localparam int TOTAL     = 16 * BPR;
    localparam int DONE_BASE = 16 * (BPR + 1) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             busy, done, tx_valid;
    logic             tx_ready = 1'b1;
    logic [3:0]       monitor_sel;
    logic [WIDTH-1:0] monitor_data;
    logic [7:0]       tx_data;
    logic [WIDTH-1:0] regs [16];

    int checks = 0;
    int errors = 0;

    // model state
    logic [7:0] mq[$];
    logic [7:0] got[$];
    bit  m_known = 0, m_busy = 0, m_capt = 0, m_done = 0, exp_valid = 0;
    int  cyc = 0, acc_cyc = 0, done_cnt = 0, done_rel = -1;

    regfile_dump #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .monitor_sel(monitor_sel), .monitor_data(monitor_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    assign monitor_data = regs[monitor_sel];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare; inputs are stable here and are what the next edge samples.
    always @(negedge clk) begin
        bit nc, nd;
        cyc++;
        exp_valid = m_busy && !m_capt && !m_done && (mq.size() > 0);
        if (m_known) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("tx_valid", tx_valid, exp_valid);
            if (exp_valid) chk("tx_data", tx_data, mq[0]);
            if (done) begin
                done_cnt++;
                done_rel = cyc - acc_cyc;
            end
        end
        if (rst) begin
            mq.delete();
            m_busy = 0; m_capt = 0; m_done = 0;
            m_known = 1;
        end else if (m_known) begin
            nc = 0; nd = 0;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1;
                    nc = 1;
                    acc_cyc = cyc;
                    done_cnt = 0;
                    done_rel = -1;
                    got.delete();
                    for (int i = 0; i < 16; i++) begin
                        if (HOFF != 0) mq.push_back(8'(i));
                        for (int b = NB - 1; b >= 0; b--) mq.push_back(8'(regs[i] >> (8 * b)));
                    end
                end
            end else if (m_done) begin
                m_busy = 0;
            end else if (exp_valid && tx_ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) nd = 1;
                else if (mq.size() % BPR == 0) nc = 1;
            end
            m_capt = nc;
            m_done = nd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns in cycle 1 of the dump.
    task automatic start_dump();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(done_cnt > 0 && !m_busy) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            errors++;
            $display("FAIL %s timeout waiting for done", name);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_done"}, done, 1'b0);
        chk({name, "_tx_valid"}, tx_valid, 1'b0);
        chk({name, "_tx_data"}, tx_data, 8'h00);
        chk({name, "_monitor_sel"}, monitor_sel, 4'h0);
    endtask

    initial begin
        int wc;
        for (int i = 0; i < 16; i++) regs[i] = 16'hA0B0 + 16'(i);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk_reset_outputs("reset");

        // 1: full-rate dump
        start_dump();
        wait_done("basic");
        chk("basic_bytes", got.size(), TOTAL);
        chk("basic_done_cycle", done_rel, DONE_BASE);
        chk("basic_byte0", got[HOFF], 8'hA0);
        chk("basic_byte1", got[HOFF + 1], 8'hB0);
        chk("basic_reg1_lo", got[BPR + HOFF + 1], 8'hB1);
        chk("basic_last", got[TOTAL - 1], 8'hBF);
`ifdef REGDUMP_HDR_EN
        chk("basic_hdr0", got[0], 8'h00);
        chk("basic_hdr1", got[BPR], 8'h01);
        chk("basic_hdr15", got[15 * BPR], 8'h0F);
`endif
        tick(); tick();

        // 2: tx_ready low for 5 cycles on the third byte
        start_dump();
        repeat ((HOFF != 0) ? 3 : 4) tick();
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", tx_valid, 1'b1);
            chk("stall_data", tx_data, (HOFF != 0) ? 8'hB0 : 8'hA0);
            tick();
        end
        tx_ready = 1'b1;
        wait_done("stall");
        chk("stall_bytes", got.size(), TOTAL);
        chk("stall_done_cycle", done_rel, DONE_BASE + 5);
        chk("stall_byte2", got[2], (HOFF != 0) ? 8'hB0 : 8'hA0);
        tick(); tick();

        // 3: write r[2] the cycle after its capture
        wc = 1 + (BPR + 1) * 2 + 1;
        start_dump();
        repeat (wc - 1) tick();
        regs[2] = 16'h1234;
        wait_done("snap");
        chk("snap_old_hi", got[2 * BPR + HOFF], 8'hA0);
        chk("snap_old_lo", got[2 * BPR + HOFF + 1], 8'hB2);
        tick();
        start_dump();
        wait_done("snap2");
        chk("snap_new_hi", got[2 * BPR + HOFF], 8'h12);
        chk("snap_new_lo", got[2 * BPR + HOFF + 1], 8'h34);
        regs[2] = 16'hA0B2;
        tick(); tick();

        // 4: reset in cycle 10 aborts the dump
        start_dump();
        repeat (9) tick();
        rst = 1'b1;
        tick();
        chk_reset_outputs("abort");
        rst = 1'b0;
        repeat (5) tick();
        chk("abort_no_done", done_cnt, 0);
        start_dump();
        wait_done("replay");
        chk("replay_bytes", got.size(), TOTAL);
        chk("replay_byte0", got[HOFF], 8'hA0);
        chk("replay_done_cycle", done_rel, DONE_BASE);
        tick(); tick();

        // 5: start pulses while busy (mid-dump and in the done cycle) are ignored
        start_dump();
        repeat (19) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (DONE_BASE - 21) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignore");
        repeat (4) tick();
        chk("ignore_bytes", got.size(), TOTAL);
        chk("ignore_done_cnt", done_cnt, 1);
        chk("ignore_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
